// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM states and byte-lane helpers shared by the load/store unit
package lsu_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam int LANE_W = 8;
  localparam logic [31:0] B_MASK = 32'h0000_00ff;
  localparam logic [31:0] H_MASK = 32'h0000_ffff;
  typedef enum logic [1:0] {IDLE, RD, WAIT, WR} state_t;
  function automatic logic [4:0] lane_sh(input logic [1:0] off);
    return {off, 3'b000};
  endfunction
  function automatic logic bad_req(input logic [1:0] size, input logic [1:0] off, input logic ld, input logic st);
    return size == 2'b11 || (size == SZ_H && off[0]) || (size == SZ_W && off != 2'b00) || ld == st;
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: pipeline request/response and data-memory signals of the load/store unit
interface load_store_unit_if #(parameter int ad_size = 32, parameter int d_size = 32);
  logic lsu_valid, lsu_load, lsu_store, lsu_unsigned;
  logic [1:0] lsu_size;
  logic [ad_size-1:0] lsu_addr;
  logic [d_size-1:0] lsu_wdata;
  logic lsu_busy, lsu_done, lsu_fault;
  logic [d_size-1:0] lsu_rdata;
  logic mem_read, mem_write;
  logic [ad_size-1:0] mem_addr;
  logic [d_size-1:0] mem_wdata, mem_rdata;
  modport slave (
    input lsu_valid, lsu_load, lsu_store, lsu_unsigned, lsu_size, lsu_addr, lsu_wdata, mem_rdata,
    output lsu_busy, lsu_done, lsu_fault, lsu_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
  modport master (
    output lsu_valid, lsu_load, lsu_store, lsu_unsigned, lsu_size, lsu_addr, lsu_wdata, mem_rdata,
    input lsu_busy, lsu_done, lsu_fault, lsu_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte-lane extraction with sign/zero extension for loads and lane merge for sub-word stores
module lsu_align import lsu_pkg::*; #(parameter int d_size = 32) (
  input  logic [d_size-1:0] word_i,
  input  logic [d_size-1:0] wdata_i,
  input  logic [1:0]        off_i,
  input  logic [1:0]        size_i,
  input  logic              uns_i,
  output logic [d_size-1:0] ld_o,
  output logic [d_size-1:0] st_o
);
  logic [d_size-1:0] sh, mask;
  logic sgn;
  // shift the addressed lane down for loads, build a lane mask for the read-modify-write merge
  always_comb begin
    sh = word_i >> lane_sh(off_i);
    sgn = ~uns_i & (size_i == SZ_B ? sh[LANE_W-1] : sh[2*LANE_W-1]);
    ld_o = size_i == SZ_B ? {{(d_size-LANE_W){sgn}}, sh[LANE_W-1:0]} :
           size_i == SZ_H ? {{(d_size-2*LANE_W){sgn}}, sh[2*LANE_W-1:0]} : sh;
    mask = (size_i == SZ_B ? d_size'(B_MASK) : size_i == SZ_H ? d_size'(H_MASK) : '1) << lane_sh(off_i);
    st_o = (word_i & ~mask) | ((wdata_i << lane_sh(off_i)) & mask);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage FSM issuing word reads/writes, sub-word stores as read-modify-write
module load_store_unit import lsu_pkg::*; #(parameter int ad_size = 32, parameter int d_size = 32) (
  input logic clk,
  input logic rst,
  load_store_unit_if.slave bus
);
  if (d_size != 32) begin : g_bad_cfg
    $error("load_store_unit: d_size must be 32");
  end
  state_t state_q, state_d;
  logic [1:0] off_q, size_q;
  logic uns_q, store_q, acc, flt;
  logic mem_read_q, mem_write_q, done_q, fault_q;
  logic [d_size-1:0] wdata_q, rdata_q, mem_wdata_q, ld_data, st_data;
  logic [ad_size-1:0] mem_addr_q;
  lsu_align #(.d_size(d_size)) u_align (
    .word_i(bus.mem_rdata), .wdata_i(wdata_q), .off_i(off_q), .size_i(size_q), .uns_i(uns_q),
    .ld_o(ld_data), .st_o(st_data)
  );
  // accept/fault decode and next state; word stores skip the read phase
  always_comb begin
    acc = bus.lsu_valid && state_q == IDLE;
    flt = acc && bad_req(bus.lsu_size, bus.lsu_addr[1:0], bus.lsu_load, bus.lsu_store);
    state_d = state_q;
    case (state_q)
      IDLE: state_d = acc && !flt ? (bus.lsu_store && bus.lsu_size == SZ_W ? WR : RD) : IDLE;
      RD:   state_d = WAIT;
      WAIT: state_d = store_q ? WR : IDLE;
      WR:   state_d = IDLE;
    endcase
  end
  // state, registered strobes and request capture; async reset abandons any request in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      off_q <= '0;
      size_q <= '0;
      uns_q <= 1'b0;
      store_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      mem_wdata_q <= '0;
      mem_addr_q <= '0;
      mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;
      done_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_read_q <= state_d == RD;
      mem_write_q <= state_d == WR;
      done_q <= flt || state_q == WR || (state_q == WAIT && !store_q);
      fault_q <= flt;
      if (acc) begin
        off_q <= bus.lsu_addr[1:0];
        size_q <= bus.lsu_size;
        uns_q <= bus.lsu_unsigned;
        store_q <= bus.lsu_store;
        wdata_q <= bus.lsu_wdata;
      end
      if (acc && !flt) begin
        mem_addr_q <= bus.lsu_addr >> 2;
        mem_wdata_q <= bus.lsu_wdata;
      end
      if (state_q == WAIT && store_q) mem_wdata_q <= st_data;
      if (state_q == WAIT && !store_q) rdata_q <= ld_data;
    end
  end
  assign bus.lsu_busy = state_q != IDLE;
  assign bus.lsu_done = done_q;
  assign bus.lsu_fault = fault_q;
  assign bus.lsu_rdata = rdata_q;
  assign bus.mem_read = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage controller sitting between the EX/MEM pipeline register and the word-organised data memory. It accepts one load or store per request, converts the byte address into a word index, and performs byte/half/word extraction with sign or zero extension on loads. Sub-word stores run as read-modify-write. It holds the pipeline through `lsu_busy` and reports alignment faults instead of touching memory.

## Interface
- `ad_size`, 32, width of byte address in and word-index address out
- `d_size`, 32, data width; fixed at 32 (four byte lanes), any other value is a configuration error
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; asynchronous, active-low (0 = reset)
- `lsu_valid`  in  1  request present from EX/MEM
- `lsu_load`  in  1  request is a load
- `lsu_store`  in  1  request is a store
- `lsu_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `lsu_unsigned`  in  1  zero-extend loads (else sign-extend)
- `lsu_addr`  in  ad_size  byte address
- `lsu_wdata`  in  d_size  store data, right-aligned
- `lsu_busy`  out  1  request in flight; upstream must hold
- `lsu_done`  out  1  one-cycle completion pulse
- `lsu_fault`  out  1  one-cycle pulse with `lsu_done` on rejected request
- `lsu_rdata`  out  d_size  extended load result
- `mem_read`  out  1  word read strobe to data memory
- `mem_write`  out  1  word write strobe to data memory
- `mem_addr`  out  ad_size  word index = `lsu_addr >> 2`, zero-filled MSBs
- `mem_wdata`  out  d_size  full word to write
- `mem_rdata`  in  d_size  memory read data, valid the cycle after `mem_read`

## Operation
- Request accepted at a rising edge where `lsu_valid=1` and state is IDLE; address, size, unsigned flag, and wdata are captured.
- Fault if the size is illegal, half-word `addr[0]≠0`, word `addr[1:0]≠0`, or `lsu_load` equals `lsu_store`. On a fault: no memory strobe is issued, and `lsu_done` and `lsu_fault` pulse in the next cycle.
- Little-endian byte lanes: lane k occupies bits [8k+7:8k] and is selected by `addr[1:0]`. The half-word lane is selected by `addr[1]`.
- States:
  - IDLE
  - RD: `mem_read=1`
  - WAIT: `mem_rdata` valid
  - WR: `mem_write=1`
- Transitions:
  - Word load: IDLE→RD→WAIT→IDLE. At the WAIT edge, extract and extend into `lsu_rdata` and pulse `lsu_done`.
  - Word store: IDLE→WR→IDLE. `mem_wdata` equals the captured wdata.
  - Byte/half store: IDLE→RD→WAIT→WR→IDLE. At the WAIT edge, merge the low 8/16 bits of wdata into the selected lane(s) of `mem_rdata`; the other lanes are unchanged.
- `mem_read` and `mem_write` are never high together. `mem_addr` is stable throughout a request.
- `lsu_rdata` holds the last load result. Stores and faults leave it unchanged.
- All outputs are registered. `lsu_busy = (state ≠ IDLE)`.

## Timing
- Reset values: state IDLE; `lsu_busy`, `lsu_done`, `lsu_fault`, `mem_read`, `mem_write` = 0; `lsu_rdata`, `mem_addr`, `mem_wdata` = 0.
- Latency, with the accept edge as E0 and `lsu_done` high in the cycle after the edge shown:
  - fault: E0+0, `lsu_done` high in cycle 1
  - word store: done after E1
  - load: done after E2
  - sub-word store: done after E3
- A new request can be accepted on the edge ending the `lsu_done` cycle, giving back-to-back word stores every 2 cycles.
- `lsu_valid` while busy is ignored and not queued; upstream must hold it.
- Reset asserted mid-request drops `mem_write` and `mem_read` immediately (asynchronous). The partial request is abandoned with no write after release and no `lsu_done`.

## Structure
- Package `lsu_pkg`:
  - size encodings (`SZ_B`, `SZ_H`, `SZ_W`)
  - state enum (IDLE, RD, WAIT, WR)
  - lane-select helper constants
- Sub-module `lsu_align` (combinational):
  - load path: word + offset + size + unsigned → extended data
  - store path: old word + wdata + offset + size → merged word
- The top level holds the FSM and registers only.

## Test plan
- Bench memory word 5 = 0xDEADBEEF; lb, lsu_unsigned=0, addr 0x15 → `lsu_rdata`=0xFFFFFFBE, `lsu_done` 3 cycles after accept, `mem_addr`=5.
- lbu 0x15 → 0x000000BE; lh 0x16 → 0xFFFFDEAD; lhu 0x14 → 0x0000BEEF.
- sb wdata 0x12345655 to 0x17 → one `mem_read`, then one `mem_write` with `mem_wdata`=0x55ADBEEF; a subsequent lw 0x14 returns 0x55ADBEEF.
- Each of the following → `lsu_fault` and `lsu_done` pulse 1 cycle later, no memory strobes, `lsu_rdata` unchanged:
  - lw 0x16
  - sh 0x13
  - size=11
  - load and store both high
- sw 0x00000047 to 0x40 held back-to-back with lw 0x40 → second request stalled by `lsu_busy`, then `lsu_rdata`=0x47.
- `rst`=0 during WAIT of an sb → `mem_write` never asserts and the word is unchanged; the first request after release completes normally.
